// File: rtl/result_word_packer_pkg.sv
// Shared types and defaults for the result word packer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: packer_state_e (FILL/HOLD), DEFAULT_WORD_W.
// Optional feature macro used by this block: RESULT_WORD_PACKER_PARITY_EN.
package result_pack_pkg;

  // FILL: shift register is accepting bits.
  // HOLD: a completed word sits in the shift register waiting for the
  //       output register to drain.
  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } packer_state_e;

  localparam int DEFAULT_WORD_W = 8;

endpackage

// File: rtl/result_word_packer_if.sv
// Bit-in / word-out bus of the result word packer.
// Latency: n/a (signal bundle only).
// Backpressure: in_ready gates the bit stream, out_ready gates word transfer.
// Ports: in_valid/in_bit/in_ready, clear, out_valid/out_ready/out_word/
//        out_ones, overflow, plus out_parity when RESULT_WORD_PACKER_PARITY_EN
//        is defined. slave = packer side, master = producer/consumer side.
interface result_word_packer_if
  import result_pack_pkg::*;
#(
  parameter int WORD_W = DEFAULT_WORD_W
);
  localparam int CNT_W = $clog2(WORD_W + 1);

  logic              in_valid;
  logic              in_bit;
  logic              in_ready;
  logic              clear;
  logic              out_valid;
  logic              out_ready;
  logic [WORD_W-1:0] out_word;
  logic [CNT_W-1:0]  out_ones;
  logic              overflow;
`ifdef RESULT_WORD_PACKER_PARITY_EN
  logic              out_parity;

  modport master (
    output in_valid, in_bit, clear, out_ready,
    input  in_ready, out_valid, out_word, out_ones, overflow, out_parity
  );
  modport slave (
    input  in_valid, in_bit, clear, out_ready,
    output in_ready, out_valid, out_word, out_ones, overflow, out_parity
  );
`else
  modport master (
    output in_valid, in_bit, clear, out_ready,
    input  in_ready, out_valid, out_word, out_ones, overflow
  );
  modport slave (
    input  in_valid, in_bit, clear, out_ready,
    output in_ready, out_valid, out_word, out_ones, overflow
  );
`endif

endinterface

// File: rtl/result_word_packer_popcount.sv
// Counts the ones in a WORD_W-bit word.
// Latency: combinational.
// Backpressure: none.
// Ports: word (WORD_W in), ones (CNT_W out).
module result_popcount
  import result_pack_pkg::*;
#(
  parameter int WORD_W = DEFAULT_WORD_W,
  parameter int CNT_W  = $clog2(WORD_W + 1)
) (
  input  logic [WORD_W-1:0] word,
  output logic [CNT_W-1:0]  ones
);

  always_comb begin
    ones = '0;
    for (int i = 0; i < WORD_W; i++) begin
      ones = ones + CNT_W'(word[i]);
    end
  end

endmodule

// File: rtl/result_word_packer.sv
// Packs the 1-bit result stream LSB-first into WORD_W-bit words with popcount.
// Latency: last bit accepted in cycle N -> out_valid in cycle N+1 (output free).
// Backpressure: one completed word parks in the shift reg (HOLD, in_ready=0);
//   bits offered while in_ready=0 are dropped and set sticky overflow.
// Ports: clk, rst_n (async active-low), bus (result_word_packer_if.slave).
// Optional: RESULT_WORD_PACKER_PARITY_EN adds out_parity = ^out_word.
module result_word_packer
  import result_pack_pkg::*;
#(
  parameter int WORD_W = DEFAULT_WORD_W
) (
  input logic                 clk,
  input logic                 rst_n,
  result_word_packer_if.slave bus
);

  localparam int CNT_W = $clog2(WORD_W + 1);
  localparam int IDX_W = $clog2(WORD_W);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_W - 1);

  packer_state_e     state;
  logic [IDX_W-1:0]  count;
  logic [WORD_W-1:0] shift;
  logic [WORD_W-1:0] filled;
  logic [WORD_W-1:0] load_word;
  logic [CNT_W-1:0]  load_ones;
  logic [WORD_W-1:0] out_word;
  logic [CNT_W-1:0]  out_ones;
  logic              out_valid;
  logic              overflow;
  logic              in_ready;
  logic              accept;
  logic              xfer;
  logic              word_done;
  logic              load;

  assign in_ready  = (state == FILL);
  assign accept    = bus.in_valid && in_ready;
  assign xfer      = out_valid && bus.out_ready;
  assign word_done = accept && (count == LAST_IDX);

  // Shift register with the incoming bit merged in at its slot.
  always_comb begin
    filled        = shift;
    filled[count] = bus.in_bit;
  end

  // A held word takes precedence; in HOLD no new bit can be accepted anyway.
  assign load_word = (state == HOLD) ? shift : filled;

  // The output register is writable when empty or draining this cycle.
  assign load = (state == HOLD) ? xfer : (word_done && (!out_valid || bus.out_ready));

  result_popcount #(
    .WORD_W (WORD_W),
    .CNT_W  (CNT_W)
  ) u_popcount (
    .word (load_word),
    .ones (load_ones)
  );

`ifdef RESULT_WORD_PACKER_PARITY_EN
  logic out_parity;
  assign bus.out_parity = out_parity;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= FILL;
      count      <= '0;
      shift      <= '0;
      out_word   <= '0;
      out_ones   <= '0;
      out_valid  <= 1'b0;
      overflow   <= 1'b0;
`ifdef RESULT_WORD_PACKER_PARITY_EN
      out_parity <= 1'b0;
`endif
    end else if (bus.clear) begin
      state      <= FILL;
      count      <= '0;
      shift      <= '0;
      out_word   <= '0;
      out_ones   <= '0;
      out_valid  <= 1'b0;
      overflow   <= 1'b0;
`ifdef RESULT_WORD_PACKER_PARITY_EN
      out_parity <= 1'b0;
`endif
    end else begin
      if (bus.in_valid && !in_ready) begin
        overflow <= 1'b1;
      end

      // Transfer empties the output; a same-cycle load below overrides.
      if (xfer) begin
        out_valid <= 1'b0;
      end

      if (load) begin
        out_word   <= load_word;
        out_ones   <= load_ones;
        out_valid  <= 1'b1;
`ifdef RESULT_WORD_PACKER_PARITY_EN
        out_parity <= ^load_word;
`endif
      end

      case (state)
        FILL: begin
          if (accept) begin
            if (word_done) begin
              count <= '0;
              if (load) begin
                shift <= '0;
              end else begin
                shift <= filled;
                state <= HOLD;
              end
            end else begin
              shift <= filled;
              count <= count + 1'b1;
            end
          end
        end
        HOLD: begin
          if (xfer) begin
            shift <= '0;
            state <= FILL;
          end
        end
        default: state <= FILL;
      endcase
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_word  = out_word;
  assign bus.out_ones  = out_ones;
  assign bus.overflow  = overflow;

endmodule

// File: doc/result_word_packer.md
Name: result_word_packer

Overview:
- Downstream stage of the 3-input gate-logic block: consumes its 1-bit `result` stream and packs it into WORD_W-bit words, LSB-first.
- Completed words go out through a valid/ready interface, with a popcount of ones and a sticky overflow flag.
- Double-buffered: the shift register keeps filling while a completed word waits in the output register.

Parameters:
- WORD_W, 8, bits per packed word; legal range 2..32.
- CNT_W, $clog2(WORD_W+1), width of the ones count (derived; do not override).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  in_bit is valid this cycle.
- in_bit  input  1  result bit from the gate-logic stage.
- in_ready  output  1  packer can accept a bit this cycle.
- clear  input  1  synchronous flush of all state.
- out_valid  output  1  out_word/out_ones hold a completed word.
- out_ready  input  1  consumer accepts the word.
- out_word  output  WORD_W  packed bits; first accepted bit in bit 0.
- out_ones  output  CNT_W  number of 1s in out_word.
- overflow  output  1  sticky; a bit was offered while in_ready=0.

Behaviour:
- Reset (rst_n=0, asynchronous): state=FILL, bit count=0, shift reg=0, out_valid=0, out_word=0, out_ones=0, overflow=0, in_ready=1.
- Acceptance: a bit is accepted when in_valid && in_ready. It is written to shift[count] and count increments.
- States:
  - FILL: accepting bits.
  - HOLD: a completed word is stuck behind a full output register.
- FILL, bit accepted with count==WORD_W-1 (word completes):
  - If the output register is free (!out_valid, or out_valid && out_ready this cycle): next cycle out_word = completed word, out_valid=1, out_ones = its popcount. Count returns to 0; stay in FILL.
  - Otherwise go to HOLD with the completed word retained in the shift register.
- HOLD:
  - in_ready=0.
  - When out_valid && out_ready: next cycle the held word loads into the output register, out_valid stays 1, count=0, state returns to FILL.
- Latency: last bit accepted in cycle N -> out_valid=1 in cycle N+1 when the output register is free.
- Output handshake:
  - out_word/out_ones are stable while out_valid && !out_ready.
  - A transfer without a new word ready clears out_valid the next cycle.
- Back-to-back: a word completing in the same cycle as an output transfer loads directly, with no bubble and no HOLD.
- Overflow: in_valid && !in_ready sets overflow (sticky); that bit is dropped. Only clear or reset clears overflow.
- clear (synchronous, highest priority after reset):
  - Next cycle: count=0, shift=0, out_valid=0, overflow=0, state=FILL.
  - Any in-flight or held word is discarded; a bit offered in the clear cycle is ignored.
- Reset mid-word discards partial data; there is no residual state.
- Partial words are never emitted.

Optional Feature:
- Macro: RESULT_WORD_PACKER_PARITY_EN.
- When defined:
  - Extra output port out_parity (1 bit) = XOR of out_word, registered alongside out_word with the same timing and handshake.
  - Reset value is 0.
- When undefined: the port and its logic are absent, and behaviour is otherwise identical.

Decomposition:
- Package result_pack_pkg:
  - packer_state_e enum {FILL, HOLD}.
  - localparam DEFAULT_WORD_W = 8.
- One sub-module, result_popcount: combinational, WORD_W-bit input to CNT_W-bit ones count. Instantiated once on the word being loaded into the output register.

Test Plan (WORD_W=8):
- Reset then feed bits 1,0,1,1,0,0,0,1 with out_ready=1 -> cycle after the 8th bit: out_valid=1, out_word=8'h8D, out_ones=4, overflow=0.
- out_ready=0, feed 16 bits (word A=8'hFF, then word B=8'h00) -> A held stable; state=HOLD after B completes, in_ready=0. Raise out_ready -> A transfers, B appears next cycle with out_ones=0, in_ready=1.
- In HOLD, assert in_valid for 3 cycles -> overflow=1 and stays 1; those bits are absent from later words. Pulse clear -> overflow=0, out_valid=0.
- Continuous in_valid with out_ready=1 for 32 bits -> 4 words, no dropped bits, no HOLD entry, one out_valid pulse every 8 cycles.
- Assert rst_n=0 asynchronously after 5 bits -> all outputs zero immediately. Then 8 bits of 8'hA5 -> out_word=8'hA5 (no residue).
- With RESULT_WORD_PACKER_PARITY_EN: word 8'h07 -> out_parity=1; word 8'h03 -> out_parity=0.
